// File: rtl/cluster_list_builder.sv
// Gathers the per-pass clusters of one frame, in pass (priority) order, into a fixed-size list.
// The list is published with a one-cycle strobe, an overflow flag and a saturating sequence-error count.
module cluster_list_builder #(
    parameter int MXKEYBITS  = 8,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8,
    parameter int NPASS      = 8
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       valid_i,
    input  logic [2:0]                                 pass_i,
    input  logic                                       vpf_i,
    input  logic [MXKEYBITS-1:0]                       adr_i,
    input  logic [MXCNTB-1:0]                          cnt_i,
    output logic [MXCLUSTERS*(MXKEYBITS+MXCNTB)-1:0]   clusters_o,
    output logic [$clog2(MXCLUSTERS+1)-1:0]            nclusters_o,
    output logic                                       overflow_o,
    output logic                                       frame_valid_o,
    output logic [7:0]                                 err_cnt_o
);

    localparam int W  = MXKEYBITS + MXCNTB;
    localparam int CW = $clog2(MXCLUSTERS + 1);
    localparam logic [2:0]    LAST_PASS = 3'(NPASS - 1);
    localparam logic [W-1:0]  EMPTY     = {{MXCNTB{1'b0}}, {MXKEYBITS{1'b1}}};
    localparam logic [CW-1:0] FULL      = CW'(MXCLUSTERS);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      exp_reg, exp_next;
    logic [CW-1:0]   count_reg, count_next, base_count;
    logic            ovf_reg, ovf_next, base_ovf;
    logic [W-1:0]    slot_reg [MXCLUSTERS];
    logic [W-1:0]    slot_next [MXCLUSTERS];
    logic [W-1:0]    out_slot_reg [MXCLUSTERS];
    logic [CW-1:0]   nclusters_reg;
    logic            overflow_reg;
    logic            frame_valid_reg;
    logic [7:0]      err_cnt_reg;

    logic start, absorb, err_inc, publish, room, write_beat;

    // Sequencing: decide whether this beat starts a frame, extends it, or is out of order.
    always_comb begin
        state_next = state_reg;
        exp_next   = exp_reg;
        start      = 1'b0;
        absorb     = 1'b0;
        err_inc    = 1'b0;
        publish    = 1'b0;
        if (valid_i) begin
            if (state_reg == IDLE) begin
                if (pass_i == 3'd0) begin
                    start  = 1'b1;
                    absorb = 1'b1;
                end else begin
                    err_inc = 1'b1;
                end
            end else begin
                if (pass_i == exp_reg) begin
                    absorb = 1'b1;
                end else if (pass_i == 3'd0) begin
                    err_inc = 1'b1;
                    start   = 1'b1;
                    absorb  = 1'b1;
                end else begin
                    err_inc    = 1'b1;
                    state_next = IDLE;
                end
            end
            if (absorb) begin
                if (pass_i == LAST_PASS) begin
                    publish    = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = COLLECT;
                    exp_next   = pass_i + 3'd1;
                end
            end
        end
    end

    // A starting beat sees a freshly cleared working list.
    always_comb begin
        base_count = start ? '0 : count_reg;
        base_ovf   = start ? 1'b0 : ovf_reg;
        room       = (base_count < FULL);
        write_beat = absorb && vpf_i && room;
        count_next = write_beat ? base_count + CW'(1) : base_count;
        ovf_next   = base_ovf | (absorb && vpf_i && !room);
    end

    generate
        for (genvar gi = 0; gi < MXCLUSTERS; gi++) begin : g_slot
            assign slot_next[gi] = (write_beat && (base_count == CW'(gi))) ? {cnt_i, adr_i}
                                 : (start ? EMPTY : slot_reg[gi]);
            assign clusters_o[gi*W +: W] = out_slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            exp_reg         <= 3'd0;
            count_reg       <= '0;
            ovf_reg         <= 1'b0;
            nclusters_reg   <= '0;
            overflow_reg    <= 1'b0;
            frame_valid_reg <= 1'b0;
            err_cnt_reg     <= 8'd0;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                slot_reg[i]     <= EMPTY;
                out_slot_reg[i] <= EMPTY;
            end
        end else begin
            state_reg       <= state_next;
            exp_reg         <= exp_next;
            count_reg       <= count_next;
            ovf_reg         <= ovf_next;
            frame_valid_reg <= publish;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                slot_reg[i] <= slot_next[i];
            end
            if (err_inc && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
            if (publish) begin
                nclusters_reg <= count_next;
                overflow_reg  <= ovf_next;
                for (int i = 0; i < MXCLUSTERS; i++) begin
                    out_slot_reg[i] <= slot_next[i];
                end
            end
        end
    end

    assign nclusters_o   = nclusters_reg;
    assign overflow_o    = overflow_reg;
    assign frame_valid_o = frame_valid_reg;
    assign err_cnt_o     = err_cnt_reg;

endmodule

// File: tb/tb_cluster_list_builder.sv
// Directed bench: an 8-slot and a 4-slot instance share one stimulus stream.
module tb_cluster_list_builder;

    localparam logic [10:0] EMPTY = 11'h0FF;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [2:0]  pass;
    logic        vpf;
    logic [7:0]  adr;
    logic [2:0]  cnt;

    logic [87:0] clusters8;
    logic [3:0]  n8;
    logic        ovf8, fv8;
    logic [7:0]  err8;
    logic [43:0] clusters4;
    logic [2:0]  n4;
    logic        ovf4, fv4;
    logic [7:0]  err4;

    int checks = 0;
    int errors = 0;
    int strobes8 = 0;

    always #5 clock = ~clock;

    cluster_list_builder #(.MXKEYBITS(8), .MXCNTB(3), .MXCLUSTERS(8), .NPASS(8)) dut8 (
        .clock(clock), .reset(reset), .valid_i(valid), .pass_i(pass), .vpf_i(vpf),
        .adr_i(adr), .cnt_i(cnt), .clusters_o(clusters8), .nclusters_o(n8),
        .overflow_o(ovf8), .frame_valid_o(fv8), .err_cnt_o(err8)
    );

    cluster_list_builder #(.MXKEYBITS(8), .MXCNTB(3), .MXCLUSTERS(4), .NPASS(8)) dut4 (
        .clock(clock), .reset(reset), .valid_i(valid), .pass_i(pass), .vpf_i(vpf),
        .adr_i(adr), .cnt_i(cnt), .clusters_o(clusters4), .nclusters_o(n4),
        .overflow_o(ovf4), .frame_valid_o(fv4), .err_cnt_o(err4)
    );

    always @(negedge clock) begin
        if (fv8 === 1'b1) strobes8 <= strobes8 + 1;
    end

    typedef struct {
        logic       valid;
        logic [2:0] pass;
        logic       vpf;
        logic [7:0] adr;
        logic [2:0] cnt;
        logic       exp_fv;
        int         exp_err;
        int         exp_n;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic v, logic [2:0] p, logic f, logic [7:0] a, logic [2:0] c,
                                logic efv, int eerr, int en);
        vec_t r;
        r.valid = v; r.pass = p; r.vpf = f; r.adr = a; r.cnt = c;
        r.exp_fv = efv; r.exp_err = eerr; r.exp_n = en;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] p, input logic f,
                         input logic [7:0] a, input logic [2:0] c);
        valid = v; pass = p; vpf = f; adr = a; cnt = c;
        @(posedge clock);
        #1;
        $display("beat v=%0d pass=%0d vpf=%0d adr=%0d cnt=%0d -> fv=%0d n=%0d ovf=%0d err=%0d",
                 v, p, f, a, c, fv8, n8, ovf8, err8);
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [10:0] slot8(int k);
        return clusters8[k*11 +: 11];
    endfunction

    function automatic logic [10:0] slot4(int k);
        return clusters4[k*11 +: 11];
    endfunction

    initial begin
        int s0;
        reset = 1'b1; valid = 1'b0; pass = 3'd0; vpf = 1'b0; adr = 8'd0; cnt = 3'd0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        // Reset state
        for (int k = 0; k < 8; k++) chk($sformatf("reset_slot%0d", k), slot8(k), EMPTY);
        chk("reset_n", n8, 0);
        chk("reset_ovf", ovf8, 0);
        chk("reset_fv", fv8, 0);
        chk("reset_err", err8, 0);

        // Aborted frame (pass 5 out of order), then a clean frame with three clusters
        tbl[0]  = mk(1, 0, 0, 0,   0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0,   0, 0, 0, 0);
        tbl[2]  = mk(1, 2, 0, 0,   0, 0, 0, 0);
        tbl[3]  = mk(1, 5, 0, 0,   0, 0, 1, 0);
        tbl[4]  = mk(1, 0, 1, 5,   1, 0, 1, 0);
        tbl[5]  = mk(1, 1, 1, 17,  3, 0, 1, 0);
        tbl[6]  = mk(1, 2, 1, 190, 0, 0, 1, 0);
        tbl[7]  = mk(1, 3, 0, 0,   0, 0, 1, 0);
        tbl[8]  = mk(1, 4, 0, 0,   0, 0, 1, 0);
        tbl[9]  = mk(1, 5, 0, 0,   0, 0, 1, 0);
        tbl[10] = mk(1, 6, 0, 0,   0, 0, 1, 0);
        tbl[11] = mk(1, 7, 0, 0,   0, 1, 1, 3);
        tbl[12] = mk(0, 0, 0, 0,   0, 0, 1, 3);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].valid, tbl[i].pass, tbl[i].vpf, tbl[i].adr, tbl[i].cnt);
            chk($sformatf("row%0d_fv", i), fv8, tbl[i].exp_fv);
            chk($sformatf("row%0d_err", i), err8, tbl[i].exp_err);
            chk($sformatf("row%0d_n", i), n8, tbl[i].exp_n);
        end
        chk("t1_slot0", slot8(0), {3'd1, 8'd5});
        chk("t1_slot1", slot8(1), {3'd3, 8'd17});
        chk("t1_slot2", slot8(2), {3'd0, 8'd190});
        for (int k = 3; k < 8; k++) chk($sformatf("t1_slot%0d", k), slot8(k), EMPTY);
        chk("t1_ovf", ovf8, 0);

        // Overflow: eight clusters into the 4-slot instance
        for (int p = 0; p < 8; p++) drive(1, 3'(p), 1, 8'(p), 3'd1);
        chk("t2_fv4", fv4, 1);
        for (int k = 0; k < 4; k++) chk($sformatf("t2_slot4_%0d", k), slot4(k), {3'd1, 8'(k)});
        chk("t2_n4", n4, 4);
        chk("t2_ovf4", ovf4, 1);
        chk("t2_n8_full", n8, 8);
        chk("t2_ovf8", ovf8, 0);
        chk("t2_slot8_7", slot8(7), {3'd1, 8'd7});
        drive(0, 0, 0, 0, 0);
        chk("t2_fv_drop", fv8, 0);

        // Reset mid-frame, then the rest of the frame is out of order
        do_reset();
        for (int p = 0; p < 4; p++) drive(1, 3'(p), 1, 8'(40 + p), 3'd2);
        do_reset();
        s0 = strobes8;
        for (int p = 4; p < 8; p++) drive(1, 3'(p), 1, 8'(40 + p), 3'd2);
        drive(0, 0, 0, 0, 0);
        chk("t4_err", err8, 4);
        chk("t4_no_strobe", strobes8 - s0, 0);
        chk("t4_n", n8, 0);
        chk("t4_slot0", slot8(0), EMPTY);
        chk("t4_ovf", ovf8, 0);

        // Back-to-back frames with a 3-cycle valid gap inside frame 2
        do_reset();
        s0 = strobes8;
        for (int p = 0; p < 8; p++) drive(1, 3'(p), (p == 0), 8'd10, 3'd1);
        chk("t5_f1_fv", fv8, 1);
        chk("t5_f1_n", n8, 1);
        for (int p = 0; p < 4; p++) drive(1, 3'(p), 0, 0, 0);
        chk("t5_f1_fv_1cyc", fv8, 0);
        for (int g = 0; g < 3; g++) drive(0, 0, 0, 0, 0);
        drive(1, 4, 1, 100, 2);
        drive(1, 5, 0, 0, 0);
        drive(1, 6, 1, 120, 7);
        drive(1, 7, 0, 0, 0);
        chk("t5_f2_fv", fv8, 1);
        drive(0, 0, 0, 0, 0);
        chk("t5_strobes", strobes8 - s0, 2);
        chk("t5_n", n8, 2);
        chk("t5_slot0", slot8(0), {3'd2, 8'd100});
        chk("t5_slot1", slot8(1), {3'd7, 8'd120});
        for (int k = 2; k < 8; k++) chk($sformatf("t5_slot%0d", k), slot8(k), EMPTY);
        chk("t5_err", err8, 0);

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 254; i++) drive(1, 3, 0, 0, 0);
        chk("t6_err254", err8, 254);
        drive(1, 3, 0, 0, 0);
        chk("t6_err255", err8, 255);
        for (int i = 0; i < 45; i++) drive(1, 3, 0, 0, 0);
        chk("t6_err_sat", err8, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
